// File: rtl/usb_speed_autodetect_pkg.sv
// Shared types and constants for the USB speed auto-detect sequencer.
package usb_speed_autodetect_pkg;

  // Speed codes shared with the USB register block. AUTO is never driven
  // on O_speed; it only exists so the register block can request detection.
  localparam logic [1:0] USB_SPEED_AUTO = 2'd0;
  localparam logic [1:0] USB_SPEED_LS   = 2'd1;
  localparam logic [1:0] USB_SPEED_FS   = 2'd2;
  localparam logic [1:0] USB_SPEED_HS   = 2'd3;

  // UTMI linestate encodings (full-speed signalling view).
  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_J   = 2'b01;
  localparam logic [1:0] LINE_K   = 2'b10;
  localparam logic [1:0] LINE_SE1 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_CHIRP,
    ST_DONE
  } state_t;

  // Transceiver setting for a detected speed, packed as {xcvrsel, termsel}.
  function automatic logic [2:0] speed_xcvr(input logic [1:0] spd);
    logic [2:0] r;
    case (spd)
      USB_SPEED_HS: r = 3'b00_0;
      USB_SPEED_LS: r = 3'b10_1;
      default:      r = 3'b01_1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/usb_speed_autodetect_if.sv
// Register-block side signal bundle of the speed auto-detect sequencer.
interface usb_speed_autodetect_if #(
  parameter int pUSB_AUTO_COUNTER_WIDTH = 24
);
  logic                               I_restart;
  logic [pUSB_AUTO_COUNTER_WIDTH-1:0] I_wait1;
  logic [pUSB_AUTO_COUNTER_WIDTH-1:0] I_wait2;
  logic [1:0]                         I_xcvrsel_default;
  logic                               I_termsel_default;
  logic [1:0]                         I_linestate;
  logic [1:0]                         O_speed;
  logic [1:0]                         O_xcvrsel;
  logic                               O_termsel;
  logic                               O_busy;
  logic                               O_done;

  modport master (
    output I_restart, I_wait1, I_wait2, I_xcvrsel_default, I_termsel_default, I_linestate,
    input  O_speed, O_xcvrsel, O_termsel, O_busy, O_done
  );

  modport slave (
    input  I_restart, I_wait1, I_wait2, I_xcvrsel_default, I_termsel_default, I_linestate,
    output O_speed, O_xcvrsel, O_termsel, O_busy, O_done
  );
endinterface

// File: rtl/usb_speed_autodetect_chirp.sv
// High-speed chirp qualifier: measures K/J run lengths and counts
// alternating qualified chirps (first one K) until enough are seen.
module usb_chirp_detect
  import usb_speed_autodetect_pkg::*;
#(
  parameter int pCHIRP_MIN   = 1500,
  parameter int pCHIRP_COUNT = 6
) (
  input  logic       fe_clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] linestate,
  output logic       hs_detect
);

  localparam int RW = $clog2(pCHIRP_MIN + 1);
  localparam int CW = $clog2(pCHIRP_COUNT + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(pCHIRP_MIN - 1);
  localparam logic [RW-1:0] RUN_SAT  = RW'(pCHIRP_MIN);
  localparam logic [CW-1:0] CNT_LAST = CW'(pCHIRP_COUNT - 1);

  logic [RW-1:0] run_cnt;
  logic [RW-1:0] run_idx;
  logic [1:0]    prev_ls;
  logic [1:0]    last_sym;
  logic          have_last;
  logic [CW-1:0] chirp_cnt;
  logic          is_kj;
  logic          qualify;
  logic          accept;

  // Position of the current cycle within its run; saturating so a long run qualifies once.
  always_comb begin
    run_idx = '0;
    if (linestate == prev_ls) begin
      run_idx = (run_cnt >= RUN_SAT) ? RUN_SAT : run_cnt + RW'(1);
    end
    is_kj     = (linestate == LINE_K) || (linestate == LINE_J);
    qualify   = en && is_kj && (run_idx == RUN_LAST);
    accept    = qualify && (have_last ? (linestate != last_sym) : (linestate == LINE_K));
    hs_detect = accept && (chirp_cnt == CNT_LAST);
  end

  // Run-length and alternation state; cleared whenever the sequencer is not listening.
  always_ff @(posedge fe_clk) begin
    if (!reset_n) begin
      run_cnt   <= '0;
      prev_ls   <= LINE_SE0;
      last_sym  <= LINE_SE0;
      have_last <= 1'b0;
      chirp_cnt <= '0;
    end else if (clr) begin
      run_cnt   <= '0;
      prev_ls   <= linestate;
      last_sym  <= LINE_SE0;
      have_last <= 1'b0;
      chirp_cnt <= '0;
    end else if (en) begin
      run_cnt <= run_idx;
      prev_ls <= linestate;
      if (accept) begin
        chirp_cnt <= chirp_cnt + CW'(1);
        last_sym  <= linestate;
        have_last <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_speed_autodetect.sv
// Speed auto-detect sequencer: settle, sample linestate, optionally listen
// for an HS chirp, then report the speed and drive the matching transceiver mode.
module usb_speed_autodetect
  import usb_speed_autodetect_pkg::*;
#(
  parameter int pUSB_AUTO_COUNTER_WIDTH = 24,
  parameter int pCHIRP_MIN              = 1500,
  parameter int pCHIRP_COUNT            = 6
) (
  input  logic                   fe_clk,
  input  logic                   reset_n,
  usb_speed_autodetect_if.slave  bus
);

  localparam int W = pUSB_AUTO_COUNTER_WIDTH;

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] timer;
  logic [W-1:0] wait1_m1;
  logic [W-1:0] wait2_m1;
  logic         timer_clr;
  logic         set_speed;
  logic [1:0]   speed_nxt;
  logic [1:0]   speed_r;
  logic         busy_r;
  logic         done_r;
  logic         chirp_clr;
  logic         chirp_en;
  logic         chirp_hs;
  logic [2:0]   speed_mode;

  // A zero wait behaves like a one-cycle wait.
  assign wait1_m1 = (bus.I_wait1 == '0) ? '0 : bus.I_wait1 - W'(1);
  assign wait2_m1 = (bus.I_wait2 == '0) ? '0 : bus.I_wait2 - W'(1);

  assign chirp_en  = (state == ST_CHIRP) && !bus.I_restart;
  assign chirp_clr = bus.I_restart || (state != ST_CHIRP);

  usb_chirp_detect #(
    .pCHIRP_MIN   (pCHIRP_MIN),
    .pCHIRP_COUNT (pCHIRP_COUNT)
  ) u_chirp (
    .fe_clk    (fe_clk),
    .reset_n   (reset_n),
    .clr       (chirp_clr),
    .en        (chirp_en),
    .linestate (bus.I_linestate),
    .hs_detect (chirp_hs)
  );

  // State register.
  always_ff @(posedge fe_clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and decision logic; a restart overrides any same-cycle decision.
  always_comb begin
    state_nxt = state;
    timer_clr = 1'b0;
    set_speed = 1'b0;
    speed_nxt = speed_r;
    if (bus.I_restart) begin
      state_nxt = ST_SETTLE;
      timer_clr = 1'b1;
    end else begin
      case (state)
        ST_SETTLE: if (timer >= wait1_m1) state_nxt = ST_SAMPLE;
        ST_SAMPLE: begin
          timer_clr = 1'b1;
          case (bus.I_linestate)
            LINE_J:  state_nxt = ST_CHIRP;
            LINE_K: begin
              state_nxt = ST_DONE;
              set_speed = 1'b1;
              speed_nxt = USB_SPEED_LS;
            end
            default: state_nxt = ST_SETTLE;
          endcase
        end
        ST_CHIRP: begin
          if (chirp_hs) begin
            state_nxt = ST_DONE;
            set_speed = 1'b1;
            speed_nxt = USB_SPEED_HS;
          end else if (timer >= wait2_m1) begin
            state_nxt = ST_DONE;
            set_speed = 1'b1;
            speed_nxt = USB_SPEED_FS;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Shared settle/listen timer, saturating at all-ones.
  always_ff @(posedge fe_clk) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (timer_clr) begin
      timer <= '0;
    end else if (((state == ST_SETTLE) || (state == ST_CHIRP)) && (timer != '1)) begin
      timer <= timer + W'(1);
    end
  end

  // Registered status outputs; speed only changes when a new result is decided.
  always_ff @(posedge fe_clk) begin
    if (!reset_n) begin
      speed_r <= USB_SPEED_FS;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      if (set_speed) speed_r <= speed_nxt;
      busy_r <= (state == ST_SETTLE) || (state == ST_SAMPLE) || (state == ST_CHIRP);
      done_r <= !bus.I_restart && (state == ST_DONE);
    end
  end

  assign speed_mode    = speed_xcvr(speed_r);
  assign bus.O_speed   = speed_r;
  assign bus.O_busy    = busy_r;
  assign bus.O_done    = done_r;
  assign bus.O_xcvrsel = done_r ? speed_mode[2:1] : bus.I_xcvrsel_default;
  assign bus.O_termsel = done_r ? speed_mode[0]   : bus.I_termsel_default;

endmodule

// File: tb/tb_usb_speed_autodetect.sv
// Self-checking bench for usb_speed_autodetect with a behavioural speed model.
module tb_usb_speed_autodetect;

  localparam int CMIN = 4;
  localparam int CCNT = 6;
  localparam logic [1:0] SE0 = 2'b00, J = 2'b01, K = 2'b10;

  logic fe_clk = 1'b0;
  logic reset_n;
  always #5 fe_clk = ~fe_clk;

  usb_speed_autodetect_if #(.pUSB_AUTO_COUNTER_WIDTH(24)) bus ();

  usb_speed_autodetect #(
    .pUSB_AUTO_COUNTER_WIDTH (24),
    .pCHIRP_MIN              (CMIN),
    .pCHIRP_COUNT            (CCNT)
  ) dut (
    .fe_clk  (fe_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int w1 = 10;
  int w2 = 100;
  logic [1:0] prev_spd;
  logic [1:0] seq[$];
  logic od[$];
  logic ob[$];
  logic [1:0] os[$];
  logic [1:0] ox[$];
  logic ot[$];

  task automatic add_run(input logic [1:0] sym, input int len);
    for (int i = 0; i < len; i++) seq.push_back(sym);
  endtask

  function automatic logic [1:0] ls_at(input int k);
    if (k >= seq.size()) return seq[seq.size()-1];
    return seq[k];
  endfunction

  // Expected transceiver mode {xcvrsel, termsel} once a speed is reported.
  function automatic logic [2:0] exp_mode(input logic [1:0] s);
    if (s == 2'd3) return 3'b000;
    if (s == 2'd1) return 3'b101;
    return 3'b011;
  endfunction

  // Behavioural model: offset k of seq is the linestate seen at the k-th edge
  // after the restart edge (k=0). Returns the deciding edge and speed.
  function automatic void model(output int d, output logic [1:0] spd);
    int e1, e2, s, rl, cnt, t;
    logic [1:0] last, cur;
    e1 = (w1 == 0) ? 1 : w1;
    e2 = (w2 == 0) ? 1 : w2;
    d = -1; spd = 2'd2;
    s = 1 + e1;
    while (ls_at(s) != J) begin
      if (ls_at(s) == K) begin d = s; spd = 2'd1; return; end
      s = s + 1 + e1;
      if (s > 4000) return;
    end
    rl = 1; cnt = 0; last = SE0;
    for (int e = s + 1; e < s + 5000; e++) begin
      t = e - (s + 1);
      cur = ls_at(e);
      rl = (cur == ls_at(e - 1)) ? rl + 1 : 1;
      if (rl == CMIN && (cur == J || cur == K)) begin
        if ((last == SE0) ? (cur == K) : (cur != last)) begin
          cnt++; last = cur;
        end
      end
      if (cnt == CCNT) begin d = e; spd = 2'd3; return; end
      if (t >= e2 - 1) begin d = e; spd = 2'd2; return; end
    end
  endfunction

  // Restart at k=0 (and again at k=kill if kill>=0), replay seq, capture outputs #1 after each edge.
  task automatic drive_case(input int kill, input int ncyc);
    od.delete(); ob.delete(); os.delete(); ox.delete(); ot.delete();
    bus.I_wait1 = 24'(w1);
    bus.I_wait2 = 24'(w2);
    for (int k = 0; k < ncyc; k++) begin
      bus.I_restart   = (k == 0) || (k == kill);
      bus.I_linestate = ls_at(k);
      @(posedge fe_clk); #1;
      od.push_back(bus.O_done);
      ob.push_back(bus.O_busy);
      os.push_back(bus.O_speed);
      ox.push_back(bus.O_xcvrsel);
      ot.push_back(bus.O_termsel);
    end
    bus.I_restart = 1'b0;
  endtask

  function automatic int first_done();
    foreach (od[i]) if (od[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    bus.I_restart = 0; bus.I_linestate = J;
    bus.I_wait1 = 24'(w1); bus.I_wait2 = 24'(w2);
    bus.I_xcvrsel_default = 2'b01; bus.I_termsel_default = 1'b1;
    reset_n = 0;
    repeat (3) @(posedge fe_clk);
    #1 reset_n = 1;
    @(posedge fe_clk); #1;
    n_cmp++; if (bus.O_speed !== 2'd2) begin n_bad++; $display("FAIL reset_speed got %0d want 2", bus.O_speed); end
    n_cmp++; if (bus.O_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.O_done); end
    n_cmp++; if (bus.O_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.O_busy); end
    n_cmp++; if (bus.O_xcvrsel !== 2'b01) begin n_bad++; $display("FAIL reset_xcvrsel got %b want 01", bus.O_xcvrsel); end
    n_cmp++; if (bus.O_termsel !== 1'b1) begin n_bad++; $display("FAIL reset_termsel got %b want 1", bus.O_termsel); end
    bus.I_xcvrsel_default = 2'b11; bus.I_termsel_default = 1'b0;
    #1;
    n_cmp++; if (bus.O_xcvrsel !== 2'b11) begin n_bad++; $display("FAIL default_follow_x got %b want 11", bus.O_xcvrsel); end
    n_cmp++; if (bus.O_termsel !== 1'b0) begin n_bad++; $display("FAIL default_follow_t got %b want 0", bus.O_termsel); end
    bus.I_xcvrsel_default = 2'b01; bus.I_termsel_default = 1'b1;
    prev_spd = 2'd2;
  endtask

  task automatic test_ls();
    int d; logic [1:0] spd;
    seq.delete(); add_run(K, 40);
    model(d, spd);
    drive_case(-1, d + 4);
    n_cmp++; if (first_done() !== 12) begin n_bad++; $display("FAIL ls_done_cycle got %0d want 12", first_done()); end
    n_cmp++; if (os[12] !== 2'd1) begin n_bad++; $display("FAIL ls_speed got %0d want 1", os[12]); end
    n_cmp++; if (ox[12] !== 2'b10) begin n_bad++; $display("FAIL ls_xcvrsel got %b want 10", ox[12]); end
    n_cmp++; if (ot[12] !== 1'b1) begin n_bad++; $display("FAIL ls_termsel got %b want 1", ot[12]); end
    n_cmp++; if (ob[0] !== 1'b0 || ob[1] !== 1'b1) begin n_bad++; $display("FAIL ls_busy_start got %b%b want 01", ob[0], ob[1]); end
    n_cmp++; if (ob[12] !== 1'b0) begin n_bad++; $display("FAIL ls_busy_end got %b want 0", ob[12]); end
    prev_spd = 2'd1;
  endtask

  task automatic test_fs_timeout();
    int d; logic [1:0] spd;
    seq.delete(); add_run(J, 200);
    model(d, spd);
    drive_case(-1, d + 4);
    n_cmp++; if (first_done() !== 112) begin n_bad++; $display("FAIL fs_done_cycle got %0d want 112", first_done()); end
    n_cmp++; if (os[112] !== 2'd2) begin n_bad++; $display("FAIL fs_speed got %0d want 2", os[112]); end
    n_cmp++; if (os[110] !== 2'd1) begin n_bad++; $display("FAIL fs_speed_hold got %0d want 1", os[110]); end
    n_cmp++; if (ox[112] !== 2'b01 || ot[112] !== 1'b1) begin n_bad++; $display("FAIL fs_mode got %b/%b want 01/1", ox[112], ot[112]); end
    prev_spd = 2'd2;
  endtask

  task automatic build_hs(input int len);
    seq.delete(); add_run(J, 12);
    for (int i = 0; i < 6; i++) add_run((i % 2 == 0) ? K : J, len);
  endtask

  task automatic test_hs();
    int d; logic [1:0] spd;
    build_hs(5); add_run(SE0, 20);
    model(d, spd);
    drive_case(-1, d + 4);
    n_cmp++; if (first_done() !== 41) begin n_bad++; $display("FAIL hs_done_cycle got %0d want 41", first_done()); end
    n_cmp++; if (os[41] !== 2'd3) begin n_bad++; $display("FAIL hs_speed got %0d want 3", os[41]); end
    n_cmp++; if (os[39] !== 2'd2) begin n_bad++; $display("FAIL hs_speed_hold got %0d want 2", os[39]); end
    n_cmp++; if (ox[41] !== 2'b00 || ot[41] !== 1'b0) begin n_bad++; $display("FAIL hs_mode got %b/%b want 00/0", ox[41], ot[41]); end
    prev_spd = 2'd3;
  endtask

  task automatic test_no_hs();
    int d; logic [1:0] spd;
    build_hs(3); add_run(SE0, 200);
    model(d, spd);
    drive_case(-1, d + 4);
    n_cmp++; if (first_done() !== 112) begin n_bad++; $display("FAIL short_done_cycle got %0d want 112", first_done()); end
    n_cmp++; if (os[112] !== 2'd2) begin n_bad++; $display("FAIL short_speed got %0d want 2", os[112]); end
    seq.delete(); add_run(J, 12);
    add_run(K, 5); add_run(SE0, 2); add_run(K, 5);
    add_run(J, 5); add_run(K, 5); add_run(J, 5); add_run(K, 5); add_run(SE0, 200);
    model(d, spd);
    drive_case(-1, d + 4);
    n_cmp++; if (first_done() !== 112) begin n_bad++; $display("FAIL repeat_done_cycle got %0d want 112", first_done()); end
    n_cmp++; if (os[112] !== 2'd2) begin n_bad++; $display("FAIL repeat_speed got %0d want 2", os[112]); end
    prev_spd = 2'd2;
  endtask

  task automatic test_se0_retry();
    int d; logic [1:0] spd;
    seq.delete(); add_run(SE0, 12); add_run(K, 40);
    model(d, spd);
    drive_case(-1, d + 4);
    n_cmp++; if (first_done() !== 23) begin n_bad++; $display("FAIL retry_done_cycle got %0d want 23", first_done()); end
    n_cmp++; if (os[23] !== 2'd1) begin n_bad++; $display("FAIL retry_speed got %0d want 1", os[23]); end
    n_cmp++; if (ob[12] !== 1'b1) begin n_bad++; $display("FAIL retry_busy got %b want 1", ob[12]); end
    prev_spd = 2'd1;
  endtask

  task automatic test_restart_mid_chirp();
    int d; logic [1:0] spd;
    seq.delete(); add_run(J, 12); add_run(K, 5); add_run(J, 5); add_run(K, 5); add_run(SE0, 200);
    drive_case(28, 31);
    n_cmp++; if (od[28] !== 1'b0 || od[30] !== 1'b0) begin n_bad++; $display("FAIL midkill_done got %b%b want 00", od[28], od[30]); end
    n_cmp++; if (ob[29] !== 1'b1) begin n_bad++; $display("FAIL midkill_busy got %b want 1", ob[29]); end
    model(d, spd);
    drive_case(-1, d + 4);
    n_cmp++; if (ob[0] !== 1'b1) begin n_bad++; $display("FAIL midkill_busy_carry got %b want 1", ob[0]); end
    n_cmp++; if (first_done() !== 112) begin n_bad++; $display("FAIL midkill_done_cycle got %0d want 112", first_done()); end
    n_cmp++; if (os[112] !== 2'd2) begin n_bad++; $display("FAIL midkill_speed got %0d want 2", os[112]); end
    prev_spd = 2'd2;
  endtask

  task automatic test_restart_on_hs();
    int d; logic [1:0] spd;
    build_hs(5); add_run(SE0, 20);
    model(d, spd);
    drive_case(d, d + 4);
    for (int k = d; k < d + 4; k++) begin
      n_cmp++; if (od[k] !== 1'b0) begin n_bad++; $display("FAIL hskill_done k=%0d got %b want 0", k, od[k]); end
      n_cmp++; if (os[k] !== prev_spd) begin n_bad++; $display("FAIL hskill_speed k=%0d got %0d want %0d", k, os[k], prev_spd); end
    end
    seq.delete(); add_run(K, 40);
    drive_case(-1, 16);
    n_cmp++; if (first_done() !== 12) begin n_bad++; $display("FAIL hskill_next_done got %0d want 12", first_done()); end
    prev_spd = 2'd1;
  endtask

  task automatic test_wait_change();
    bus.I_wait1 = 24'(w1); bus.I_wait2 = 24'(100);
    for (int k = 0; k < 64; k++) begin
      bus.I_restart = (k == 0);
      bus.I_linestate = J;
      if (k == 60) bus.I_wait2 = 24'(20);
      @(posedge fe_clk); #1;
      n_cmp++;
      if (bus.O_done !== (k >= 61)) begin n_bad++; $display("FAIL waitchg_done k=%0d got %b want %b", k, bus.O_done, (k >= 61)); end
    end
    n_cmp++; if (bus.O_speed !== 2'd2) begin n_bad++; $display("FAIL waitchg_speed got %0d want 2", bus.O_speed); end
    bus.I_wait2 = 24'(w2);
    prev_spd = 2'd2;
  endtask

  task automatic test_random();
    int d, mode, rise; logic [1:0] spd, sym, nxt;
    for (int it = 0; it < 8; it++) begin
      w1 = $urandom_range(0, 12);
      w2 = $urandom_range(30, 120);
      mode = $urandom_range(0, 3);
      seq.delete();
      add_run((mode == 0) ? K : (mode == 1) ? SE0 : J, 2 + w1);
      if (mode == 1) add_run(J, 1 + w1);
      nxt = K;
      for (int r = 0; r < 14; r++) begin
        if (mode >= 2 && $urandom_range(0, 4) != 0) sym = nxt;
        else sym = 2'($urandom_range(0, 3));
        if (sym == nxt) nxt = (nxt == K) ? J : K;
        add_run(sym, $urandom_range(2, 7));
      end
      add_run(SE0, 10);
      model(d, spd);
      if (d < 0) begin
        n_cmp++; n_bad++; $display("FAIL rand_model it=%0d got no decision want one", it);
      end else begin
        drive_case(-1, d + 4);
        rise = first_done();
        n_cmp++; if (rise !== d + 1) begin n_bad++; $display("FAIL rand_done it=%0d got %0d want %0d", it, rise, d + 1); end
        n_cmp++; if (os[d + 1] !== spd) begin n_bad++; $display("FAIL rand_speed it=%0d got %0d want %0d", it, os[d + 1], spd); end
        n_cmp++; if (d >= 1 && os[d - 1] !== prev_spd) begin n_bad++; $display("FAIL rand_hold it=%0d got %0d want %0d", it, os[d - 1], prev_spd); end
        n_cmp++; if ({ox[d + 2], ot[d + 2]} !== exp_mode(spd)) begin n_bad++; $display("FAIL rand_mode it=%0d got %b want %b", it, {ox[d + 2], ot[d + 2]}, exp_mode(spd)); end
        n_cmp++; if (ob[d] !== 1'b1 || ob[d + 1] !== 1'b0) begin n_bad++; $display("FAIL rand_busy it=%0d got %b%b want 10", it, ob[d], ob[d + 1]); end
        prev_spd = spd;
      end
    end
    w1 = 10; w2 = 100;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ls();
    test_fs_timeout();
    test_hs();
    test_no_hs();
    test_se0_retry();
    test_restart_mid_chirp();
    test_restart_on_hs();
    test_wait_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
